// File: rtl/regfile_arbiter_if.sv
// Requester-side bus for the two ports (A, B) of regfile_arbiter.
// master = requester view, slave = arbiter view.
interface regfile_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  logic          a_req, a_we, a_ack, a_err;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_we, b_ack, b_err;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
    input  a_ack, a_err, a_rdata, b_ack, b_err, b_rdata
  );
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
    output a_ack, a_err, a_rdata, b_ack, b_err, b_rdata
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-port IDLE/ACCESS/ACK sequencer in front of a one-hot-selected register file.
// REGFILE_ARB_FIXED_PRIO_EN: port A always wins ties (no last-grant state); otherwise round-robin.
module regfile_arbiter #(
  parameter int NREGS = 10,
  parameter int DW    = 32,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              reset,
  regfile_arbiter_if.slave  bus,
  output logic [NREGS-1:0]  rf_wsel,
  output logic [NREGS-1:0]  rf_rsel,
  output logic [DW-1:0]     rf_din,
  input  logic [DW-1:0]     rf_dout
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_e;

  localparam logic [AW:0]      NREGS_W = (AW+1)'(NREGS);
  localparam logic [NREGS-1:0] ONE     = {{(NREGS-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic                 win_q, win_d;          // 0 = A, 1 = B
  logic                 we_q, we_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic                 err_q, err_d;
  logic [1:0][DW-1:0]   rdata_q, rdata_d;
  logic                 pick_b, in_range, access, ack_a, ack_b;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  assign pick_b = bus.b_req & ~bus.a_req;
`else
  logic last_q, last_d;                         // 1 = B granted last

  assign pick_b = bus.b_req & (~bus.a_req | ~last_q);

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && (bus.a_req || bus.b_req)) last_d = pick_b;
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`endif

  assign in_range = ({1'b0, addr_q} < NREGS_W);
  // Reset gates the selects so a write in flight never reaches the file.
  assign access   = (state_q == ACCESS) && !reset;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (bus.a_req || bus.b_req) begin
        state_d = ACCESS;
        win_d   = pick_b;
        we_d    = pick_b ? bus.b_we    : bus.a_we;
        addr_d  = pick_b ? bus.b_addr  : bus.a_addr;
        wdata_d = pick_b ? bus.b_wdata : bus.a_wdata;
      end
      ACCESS: begin
        state_d = ACK;
        err_d   = !in_range;
        if (!in_range)  rdata_d[win_q] = '0;
        else if (!we_q) rdata_d[win_q] = rf_dout;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rf_wsel = '0;
    rf_rsel = '0;
    rf_din  = '0;
    if (access && in_range) begin
      if (we_q) begin
        rf_wsel = ONE << addr_q;
        rf_din  = wdata_q;
      end else begin
        rf_rsel = ONE << addr_q;
      end
    end
  end

  assign ack_a       = (state_q == ACK) && !win_q && !reset;
  assign ack_b       = (state_q == ACK) &&  win_q && !reset;
  assign bus.a_ack   = ack_a;
  assign bus.b_ack   = ack_b;
  assign bus.a_err   = ack_a & err_q;
  assign bus.b_err   = ack_b & err_q;
  assign bus.a_rdata = rdata_q[0];
  assign bus.b_rdata = rdata_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: vector table plus reset-abort, dropped-request
// and contention sequences against a small behavioural register file.
module tb_regfile_arbiter;
  localparam int NREGS = 10;
  localparam int DW    = 32;
  localparam int AW    = 4;

  logic             clk, reset;
  logic [NREGS-1:0] rf_wsel, rf_rsel;
  logic [DW-1:0]    rf_din, rf_dout;
  logic [DW-1:0]    regs [NREGS] = '{default: '0};

  int checks   = 0;
  int failures = 0;

  regfile_arbiter_if #(.DW(DW), .AW(AW)) rif ();

  regfile_arbiter #(.NREGS(NREGS), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .bus(rif.slave),
    .rf_wsel(rf_wsel), .rf_rsel(rf_rsel), .rf_din(rf_din), .rf_dout(rf_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: synchronous one-hot write, combinational one-hot read, no reset.
  always_ff @(posedge clk)
    for (int i = 0; i < NREGS; i++) if (rf_wsel[i]) regs[i] <= rf_din;

  always_comb begin
    rf_dout = '0;
    for (int i = 0; i < NREGS; i++) if (rf_rsel[i]) rf_dout = regs[i];
  end

  typedef struct {
    bit          port;
    bit          we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [9:0]  exp_wsel;
    logic [9:0]  exp_rsel;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] last_rd [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input bit port, input bit we, input int addr,
                         input logic [31:0] wd, input logic [31:0] rd);
    vec_t v;
    bit   ok = (addr < NREGS);
    v.port = port; v.we = we; v.addr = 4'(addr); v.wdata = wd;
    v.exp_wsel = (ok && we)  ? 10'(1 << addr) : 10'h0;
    v.exp_rsel = (ok && !we) ? 10'(1 << addr) : 10'h0;
    v.exp_err  = !ok;
    if (!ok)      last_rd[port] = 32'h0;
    else if (!we) last_rd[port] = rd;
    v.exp_rdata = last_rd[port];
    vecs.push_back(v);
  endtask

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [3:0] addr, input logic [31:0] wd);
    if (!port) begin
      rif.a_req = req; rif.a_we = we; rif.a_addr = addr; rif.a_wdata = wd;
    end else begin
      rif.b_req = req; rif.b_we = we; rif.b_addr = addr; rif.b_wdata = wd;
    end
  endtask

  task automatic run_txn(input bit port, input bit we, input logic [3:0] addr,
                         input logic [31:0] wd, output int lat, output logic [9:0] ws,
                         output logic [9:0] rs, output logic [31:0] din,
                         output logic [31:0] rd, output bit er, output int other,
                         output int sel_bad);
    @(negedge clk);
    drive(port, 1'b1, we, addr, wd);
    lat = -1; ws = '0; rs = '0; din = '0; rd = '0; er = 1'b0; other = 0; sel_bad = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      ws |= rf_wsel;
      rs |= rf_rsel;
      if (rf_wsel != '0) din = rf_din;
      if ($countones(rf_wsel) + $countones(rf_rsel) > 1) sel_bad++;
      if (port ? rif.a_ack : rif.b_ack) other++;
      if (port ? rif.b_ack : rif.a_ack) begin
        lat = c;
        rd  = port ? rif.b_rdata : rif.a_rdata;
        er  = port ? rif.b_err   : rif.a_err;
        break;
      end
    end
    drive(port, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  initial begin
    int          lat, other, sel_bad, acks, overlap, wide, ai, bi;
    logic [9:0]  ws, rs;
    logic [31:0] din, rd;
    bit          er, pa, pb;
    int          order[$];

    // Table: first A transaction is a write (rdata still 0), first B one a read.
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    add_vec(0, 1, 3,  32'hDEADBEEF, 32'h0);
    add_vec(0, 0, 3,  32'h0,        32'hDEADBEEF);
    add_vec(1, 0, 12, 32'h0,        32'h0);
    for (int i = 0; i < NREGS; i++) add_vec(i % 2, 1, i, 32'h100 + i, 32'h0);
    for (int i = 0; i < NREGS; i++) add_vec((i + 1) % 2, 0, i, 32'h0, 32'h100 + i);
    add_vec(1, 0, 10, 32'h0, 32'h0);
    add_vec(0, 1, 15, 32'h1234, 32'h0);

    reset = 1'b1;
    drive(0, 0, 0, 4'h0, 32'h0);
    drive(1, 0, 0, 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_a_ack",   32'(rif.a_ack), 0);
    chk("rst_b_ack",   32'(rif.b_ack), 0);
    chk("rst_a_err",   32'(rif.a_err), 0);
    chk("rst_b_err",   32'(rif.b_err), 0);
    chk("rst_a_rdata", rif.a_rdata,    0);
    chk("rst_b_rdata", rif.b_rdata,    0);
    chk("rst_wsel",    32'(rf_wsel),   0);
    chk("rst_rsel",    32'(rf_rsel),   0);
    chk("rst_din",     rf_din,         0);

    // Reset lands in the ACCESS cycle of a write: write and ack must both vanish.
    @(negedge clk);
    drive(0, 1, 1, 4'd5, 32'h55);
    @(negedge clk);
    chk("abort_wsel_pre", 32'(rf_wsel), 32'h020);
    reset = 1'b1;
    drive(0, 0, 0, 4'h0, 32'h0);
    #1 chk("abort_wsel_rst", 32'(rf_wsel), 0);
    @(negedge clk);
    reset = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (rif.a_ack || rif.b_ack) acks++;
    end
    chk("abort_no_ack", acks, 0);
    run_txn(0, 0, 4'd5, 32'h0, lat, ws, rs, din, rd, er, other, sel_bad);
    chk("abort_rd5_lat", lat, 2);
    chk("abort_rd5",     rd,  0);

    // Request dropped after being latched still completes.
    @(negedge clk);
    drive(1, 1, 1, 4'd1, 32'h77);
    @(negedge clk);
    drive(1, 0, 0, 4'h0, 32'h0);
    chk("drop_wsel", 32'(rf_wsel), 32'h002);
    @(negedge clk);
    chk("drop_ack", 32'(rif.b_ack), 1);
    run_txn(1, 0, 4'd1, 32'h0, lat, ws, rs, din, rd, er, other, sel_bad);
    chk("drop_rd1", rd, 32'h77);

    foreach (vecs[i]) begin
      run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
              lat, ws, rs, din, rd, er, other, sel_bad);
      chk($sformatf("v%0d_lat", i),   lat,           2);
      chk($sformatf("v%0d_wsel", i),  32'(ws),       32'(vecs[i].exp_wsel));
      chk($sformatf("v%0d_rsel", i),  32'(rs),       32'(vecs[i].exp_rsel));
      chk($sformatf("v%0d_err", i),   32'(er),       32'(vecs[i].exp_err));
      chk($sformatf("v%0d_rdata", i), rd,            vecs[i].exp_rdata);
      chk($sformatf("v%0d_other", i), other,         0);
      chk($sformatf("v%0d_onehot", i), sel_bad,      0);
      if (vecs[i].exp_wsel != 0) chk($sformatf("v%0d_din", i), din, vecs[i].wdata);
    end

    // Both ports request continuously from reset, four writes each.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ai = 0; bi = 0; overlap = 0; wide = 0; pa = 0; pb = 0;
    drive(0, 1, 1, 4'd0, 32'hA00);
    drive(1, 1, 1, 4'd4, 32'hB00);
    for (int c = 0; c < 80 && (ai < 4 || bi < 4); c++) begin
      @(negedge clk);
      if (rif.a_ack && rif.b_ack) overlap++;
      if ((rif.a_ack && pa) || (rif.b_ack && pb)) wide++;
      pa = rif.a_ack; pb = rif.b_ack;
      if (rif.a_ack) begin
        order.push_back(0);
        ai++;
        if (ai < 4) drive(0, 1, 1, 4'(ai), 32'hA00 + ai);
        else        drive(0, 0, 0, 4'h0, 32'h0);
      end
      if (rif.b_ack) begin
        order.push_back(1);
        bi++;
        if (bi < 4) drive(1, 1, 1, 4'(4 + bi), 32'hB00 + bi);
        else        drive(1, 0, 0, 4'h0, 32'h0);
      end
    end
    chk("cont_overlap", overlap, 0);
    chk("cont_wide",    wide,    0);
    chk("cont_count",   order.size(), 8);
    foreach (order[i]) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
      chk($sformatf("cont_grant%0d", i), order[i], (i < 4) ? 0 : 1);
`else
      chk($sformatf("cont_grant%0d", i), order[i], i % 2);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Two-port arbiter/sequencer in front of the 32x10 one-hot-selected register file.
- Two requesters (port A, port B) issue single read or write transactions with binary register addresses.
- Block arbitrates round-robin, converts the address to one-hot wsel/rsel, and drives din.
- Captures dout for reads and returns ack/rdata/err to the winning requester.

Parameters:
- NREGS, 10, number of registers in the file; valid addresses 0..NREGS-1.
- DW, 32, data width.
- AW, 4, address width; must satisfy 2**AW >= NREGS.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  port A request; held high until a_ack.
- a_we  in  1  port A: 1 = write, 0 = read; stable while a_req high.
- a_addr  in  AW  port A register index; stable while a_req high.
- a_wdata  in  DW  port A write data; stable while a_req high.
- a_ack  out  1  port A one-cycle completion pulse.
- a_rdata  out  DW  port A read data; valid when a_ack=1.
- a_err  out  1  port A address out of range; valid when a_ack=1.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata, b_err  as port A, for port B.
- rf_wsel  out  NREGS  one-hot write select to the register file.
- rf_rsel  out  NREGS  one-hot read select to the register file.
- rf_din  out  DW  write data to the register file.
- rf_dout  in  DW  combinational read data from the register file.

Behaviour:
- Reset: state=IDLE; last-grant=B, so A wins the first tie.
  - All outputs 0: a_ack, b_ack, a_err, b_err, a_rdata, b_rdata, rf_wsel, rf_rsel, rf_din.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - No request: stay in IDLE.
  - Any request: choose winner, latch its we/addr/wdata and the winner id, go to ACCESS.
- Arbitration:
  - Only one request high: that port wins.
  - Both high: the port not granted last wins.
  - last-grant updates when the winner is latched.
- ACCESS (exactly one cycle):
  - Address < NREGS and write: rf_wsel = 1<<addr, rf_din = wdata, rf_rsel = 0.
  - Address < NREGS and read: rf_rsel = 1<<addr, rf_wsel = 0; rf_dout captured into the winner's rdata register at the end of the cycle.
  - Address >= NREGS: rf_wsel = rf_rsel = 0; err flag set; rdata = 0.
  - Next state: ACK.
- ACK (exactly one cycle):
  - Winner's x_ack = 1 and x_err valid; other port's ack = 0.
  - rf_wsel = rf_rsel = 0.
  - Next state: IDLE.
- Outside ACCESS: rf_wsel and rf_rsel are always 0, so at most one select bit is high in any cycle and never both wsel and rsel.
- rf_din is 0 outside ACCESS-write.
- Latency: request seen in IDLE at cycle k, ACCESS at k+1, ack at k+2; throughput 1 transaction per 3 cycles.
- x_rdata holds its last value until the next read completes on that port; a write ack leaves x_rdata unchanged.
- Handshake: the cycle after ack, the requester must drop req or present a new transaction.
  - A new request is sampled in IDLE; back-to-back from the same port is allowed.
  - Under continuous contention the ports alternate A, B, A, B…
- Request dropped before ack (protocol violation): the latched transaction still completes; ack is still pulsed.
- Reset during ACCESS or ACK:
  - Transaction aborted; no ack.
  - Write suppressed if reset is high in the ACCESS cycle, since rf_wsel is forced to 0 on reset.
  - State returns to IDLE next cycle.

Optional Feature:
- REGFILE_ARB_FIXED_PRIO_EN defined: fixed priority; A always wins when both request; last-grant register removed.
- Undefined: round-robin as above.

Test Plan:
- A write addr 3 data 0xDEADBEEF; later A read addr 3 -> rf_wsel=0x008 for one cycle; read ack 2 cycles after req with a_rdata=0xDEADBEEF, a_err=0.
- A and B both request from reset with 4 back-to-back transactions each -> grants A,B,A,B…, no ack overlap, each ack one cycle wide.
- B read addr 12 -> rf_wsel=rf_rsel=0 throughout; b_ack=1, b_err=1, b_rdata=0.
- Write all 10 registers with value 0x100+i, read back all -> each read returns 0x100+i; rf_wsel covers 0x001..0x200.
- Reset asserted in the ACCESS cycle of A write addr 5 data 0x55 -> no a_ack; read addr 5 afterwards -> register unchanged (0 after reset).
- With REGFILE_ARB_FIXED_PRIO_EN, both ports requesting continuously -> A granted every transaction, B never acked.
